discrete_value_sampler: RTL

- Downstream stage of the discrete range randomizer.
- Consumes the selected range (start, end, equal flag) for one variable and returns one uniformly distributed integer inside that range.
- Uses an internal 16-bit Galois LFSR and bounded rejection sampling, so no modulo bias.
- Its result feeds the MCMC proposal / variable-update logic, together with the variable index it belongs to.

---
 rtl/discrete_sampler_pkg.sv | 25 ++
 rtl/lfsr_galois.sv | 52 +++++
 rtl/discrete_value_sampler.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/discrete_sampler_pkg.sv
// -----------------------------------------------------------------------------
// discrete_sampler_pkg
// Shared definitions for the discrete randomizer stages: sampler FSM state
// encoding, the 16-bit Galois LFSR tap constant and the default widths used
// by both the range randomizer and the value sampler.
// -----------------------------------------------------------------------------
package discrete_sampler_pkg;

  // Default widths shared with the range randomizer.
  localparam int DEFAULT_INTEGER_WIDTH = 8;
  localparam int DEFAULT_INDEX_WIDTH   = 2;
  localparam int DEFAULT_LFSR_WIDTH    = 16;
  localparam int DEFAULT_MAX_ATTEMPTS  = 8;

  // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MASK   = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } sampler_state_t;

endpackage

// File: rtl/lfsr_galois.sv
// -----------------------------------------------------------------------------
// lfsr_galois
// Right-shifting Galois LFSR with a seed-zero guard. Reusable by any
// randomizer stage that needs a cheap pseudo-random stream.
//
// Ports:
//   in_clock   clock
//   in_reset   synchronous active-high reset; loads in_seed (0 becomes 1)
//   in_enable  global enable; the register holds when low
//   in_step    advance one Galois step this cycle (qualified by in_enable)
//   in_seed    value loaded during reset
//   out_state  low OUT_WIDTH bits of the current LFSR state
// -----------------------------------------------------------------------------
module lfsr_galois
  import discrete_sampler_pkg::*;
#(
  parameter int                 WIDTH     = DEFAULT_LFSR_WIDTH,
  parameter int                 OUT_WIDTH = WIDTH,
  parameter logic [WIDTH-1:0]   TAPS      = WIDTH'(LFSR_TAPS)
) (
  input  logic                  in_clock,
  input  logic                  in_reset,
  input  logic                  in_enable,
  input  logic                  in_step,
  input  logic [WIDTH-1:0]      in_seed,
  output logic [OUT_WIDTH-1:0]  out_state
);

  logic [WIDTH-1:0] state_reg;
  logic [WIDTH-1:0] state_next;
  logic [WIDTH-1:0] seed_safe;

  // The all-zero state is a lock-up state for an XOR LFSR, so never load it.
  always_comb begin
    seed_safe = (in_seed == '0) ? WIDTH'(1) : in_seed;
  end

  always_comb begin
    state_next = (state_reg >> 1) ^ (state_reg[0] ? TAPS : '0);
  end

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      state_reg <= seed_safe;
    end else if (in_enable && in_step) begin
      state_reg <= state_next;
    end
  end

  assign out_state = state_reg[OUT_WIDTH-1:0];

endmodule

// File: rtl/discrete_value_sampler.sv
// -----------------------------------------------------------------------------
// discrete_value_sampler
// Takes a selected range (start, end, equal flag) for one variable and returns
// one uniformly distributed integer inside it, using an internal Galois LFSR
// and bounded rejection sampling (no modulo bias). If every attempt is
// rejected, a halved candidate is used, which is always in range.
//
// Ports:
//   in_clock            clock
//   in_reset            synchronous active-high reset
//   in_enable           global enable; FSM, LFSR and outputs hold when low
//   in_seed             LFSR value loaded during reset (0 is replaced by 1)
//   in_valid            range request valid
//   out_ready           high only in IDLE
//   in_start, in_end    range bounds (either order)
//   in_equal            single-value request; result is in_start
//   in_variable_index   index passed through with the result
//   in_result_ready     consumer accepts the result
//   out_valid           result valid
//   out_value           sampled value
//   out_variable_index  index captured with the request
//   out_fallback        result came from the fallback path
// -----------------------------------------------------------------------------
module discrete_value_sampler
  import discrete_sampler_pkg::*;
#(
  parameter int MAX_BIT_WIDTH_OF_INTEGER_VARIABLE = DEFAULT_INTEGER_WIDTH,
  parameter int MAX_BIT_WIDTH_OF_VARIABLES_INDEX  = DEFAULT_INDEX_WIDTH,
  parameter int LFSR_WIDTH                        = DEFAULT_LFSR_WIDTH,
  parameter int MAX_ATTEMPTS                      = DEFAULT_MAX_ATTEMPTS
) (
  input  logic                                         in_clock,
  input  logic                                         in_reset,
  input  logic                                         in_enable,
  input  logic [LFSR_WIDTH-1:0]                        in_seed,
  input  logic                                         in_valid,
  output logic                                         out_ready,
  input  logic [MAX_BIT_WIDTH_OF_INTEGER_VARIABLE-1:0] in_start,
  input  logic [MAX_BIT_WIDTH_OF_INTEGER_VARIABLE-1:0] in_end,
  input  logic                                         in_equal,
  input  logic [MAX_BIT_WIDTH_OF_VARIABLES_INDEX-1:0]  in_variable_index,
  input  logic                                         in_result_ready,
  output logic                                         out_valid,
  output logic [MAX_BIT_WIDTH_OF_INTEGER_VARIABLE-1:0] out_value,
  output logic [MAX_BIT_WIDTH_OF_VARIABLES_INDEX-1:0]  out_variable_index,
  output logic                                         out_fallback
);

  localparam int W  = MAX_BIT_WIDTH_OF_INTEGER_VARIABLE;
  localparam int IW = MAX_BIT_WIDTH_OF_VARIABLES_INDEX;
  localparam int AW = (MAX_ATTEMPTS > 1) ? $clog2(MAX_ATTEMPTS) : 1;

  sampler_state_t state_reg, state_next;
  logic [W-1:0]   lo_reg, lo_next;
  logic [W-1:0]   hi_reg, hi_next;
  logic [W-1:0]   mask_reg, mask_next;
  logic [AW-1:0]  attempt_reg, attempt_next;
  logic [W-1:0]   value_reg, value_next;
  logic [IW-1:0]  index_reg, index_next;
  logic           valid_reg, valid_next;
  logic           fallback_reg, fallback_next;

  logic [W-1:0]   req_lo;
  logic [W-1:0]   req_hi;
  logic [W-1:0]   span;
  logic [W-1:0]   mask_smear;
  logic [W-1:0]   lfsr_low;
  logic [W-1:0]   candidate;
  logic           lfsr_step;

  // A reversed range is simply swapped.
  assign req_lo = (in_start < in_end) ? in_start : in_end;
  assign req_hi = (in_start < in_end) ? in_end   : in_start;

  assign span = hi_reg - lo_reg;

  // OR-smear: every bit at or below the MSB of span is set, giving the
  // smallest 2^k-1 mask that covers the span.
  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_smear
      assign mask_smear[gi] = |span[W-1:gi];
    end
  endgenerate

  // The LFSR only moves while sampling, so the random stream is a pure
  // function of the seed and the order of range requests.
  assign lfsr_step = (state_reg == SAMPLE);

  lfsr_galois #(
    .WIDTH     (LFSR_WIDTH),
    .OUT_WIDTH (W),
    .TAPS      (LFSR_WIDTH'(LFSR_TAPS))
  ) u_lfsr (
    .in_clock  (in_clock),
    .in_reset  (in_reset),
    .in_enable (in_enable),
    .in_step   (lfsr_step),
    .in_seed   (in_seed),
    .out_state (lfsr_low)
  );

  assign candidate = lfsr_low & mask_reg;

  always_comb begin
    state_next    = state_reg;
    lo_next       = lo_reg;
    hi_next       = hi_reg;
    mask_next     = mask_reg;
    attempt_next  = attempt_reg;
    value_next    = value_reg;
    index_next    = index_reg;
    valid_next    = valid_reg;
    fallback_next = fallback_reg;

    if (in_enable) begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            lo_next       = req_lo;
            hi_next       = req_hi;
            index_next    = in_variable_index;
            fallback_next = 1'b0;
            if (in_equal || (req_lo == req_hi)) begin
              value_next = in_start;
              valid_next = 1'b1;
              state_next = DONE;
            end else begin
              state_next = MASK;
            end
          end
        end

        MASK: begin
          mask_next    = mask_smear;
          attempt_next = '0;
          state_next   = SAMPLE;
        end

        SAMPLE: begin
          if (candidate <= span) begin
            value_next = lo_reg + candidate;
            valid_next = 1'b1;
            state_next = DONE;
          end else if (attempt_reg == AW'(MAX_ATTEMPTS - 1)) begin
            // mask <= 2*span+1, so candidate>>1 <= span and stays in range.
            value_next    = lo_reg + (candidate >> 1);
            fallback_next = 1'b1;
            valid_next    = 1'b1;
            state_next    = DONE;
          end else begin
            attempt_next = attempt_reg + 1'b1;
          end
        end

        DONE: begin
          if (in_result_ready) begin
            valid_next = 1'b0;
            state_next = IDLE;
          end
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      state_reg    <= IDLE;
      lo_reg       <= '0;
      hi_reg       <= '0;
      mask_reg     <= '0;
      attempt_reg  <= '0;
      value_reg    <= '0;
      index_reg    <= '0;
      valid_reg    <= 1'b0;
      fallback_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      lo_reg       <= lo_next;
      hi_reg       <= hi_next;
      mask_reg     <= mask_next;
      attempt_reg  <= attempt_next;
      value_reg    <= value_next;
      index_reg    <= index_next;
      valid_reg    <= valid_next;
      fallback_reg <= fallback_next;
    end
  end

  assign out_ready          = (state_reg == IDLE);
  assign out_valid          = valid_reg;
  assign out_value          = value_reg;
  assign out_variable_index = index_reg;
  assign out_fallback       = fallback_reg;

endmodule
